mem_responder: RTL and testbench

//  Synthesizable memory-side responder for cache_ctrl benches. It answers the cache controller's line-fill (read) and

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for cache_ctrl benches: line-organised array answering
// BEATS-beat line fills and writebacks after a fixed LATENCY.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int LINE_ADDR_W = 6,
    parameter int BEATS       = 4,
    parameter int LATENCY     = 3,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [LINE_ADDR_W-1:0] req_addr,
    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [DATA_W-1:0]      wd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   wr_ack,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W-1:0]       wr_count
);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MEM_AW    = LINE_ADDR_W + BEAT_W;
    localparam int MEM_DEPTH = 2 ** MEM_AW;
    localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WDATA, WAIT, RBURST, WACK} state_t;

    state_t state_reg, state_next;

    logic [LINE_ADDR_W-1:0] addr_reg;
    logic                   we_reg;
    logic [BEAT_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic [LAT_W-1:0]       lat_cnt_reg, lat_cnt_next;
    logic [CNT_W-1:0]       rd_count_reg, wr_count_reg;

    logic req_ready_reg, wd_ready_reg, rsp_valid_reg, rsp_last_reg, wr_ack_reg;
    logic req_ready_next, wd_ready_next, rsp_valid_next, rsp_last_next, wr_ack_next;
    logic [DATA_W-1:0] rsp_data_reg;

    logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};

    logic req_hs, wd_hs, rsp_hs;
    logic [MEM_AW-1:0] rd_addr;

    // Ready/valid flags are registered copies of the state, so a handshake
    // can only happen in the matching state.
    assign req_hs  = req_valid && req_ready_reg;
    assign wd_hs   = wd_valid && wd_ready_reg;
    assign rsp_hs  = rsp_valid_reg && rsp_ready;
    assign rd_addr = {addr_reg, beat_cnt_next};

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        lat_cnt_next  = lat_cnt_reg;
        case (state_reg)
            IDLE: if (req_hs) begin
                state_next    = req_we ? WDATA : WAIT;
                beat_cnt_next = '0;
                lat_cnt_next  = LAT_INIT;
            end
            WDATA: if (wd_hs) begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                if (beat_cnt_reg == LAST_BEAT) begin
                    state_next   = WAIT;
                    lat_cnt_next = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_cnt_reg == '0) state_next = we_reg ? WACK : RBURST;
                else                   lat_cnt_next = lat_cnt_reg - LAT_W'(1);
            end
            RBURST: if (rsp_hs) begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                if (rsp_last_reg) state_next = IDLE;
            end
            WACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_next = (state_next == IDLE);
        wd_ready_next  = (state_next == WDATA);
        rsp_valid_next = (state_next == RBURST);
        rsp_last_next  = (state_next == RBURST) && (beat_cnt_next == LAST_BEAT);
        wr_ack_next    = (state_next == WACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            beat_cnt_reg  <= '0;
            lat_cnt_reg   <= '0;
            rd_count_reg  <= '0;
            wr_count_reg  <= '0;
            req_ready_reg <= 1'b0;
            wd_ready_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            wr_ack_reg    <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_reg <= req_addr;
                we_reg   <= req_we;
            end
            beat_cnt_reg  <= beat_cnt_next;
            lat_cnt_reg   <= lat_cnt_next;
            req_ready_reg <= req_ready_next;
            wd_ready_reg  <= wd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_last_reg  <= rsp_last_next;
            wr_ack_reg    <= wr_ack_next;
            if (state_reg == RBURST && state_next == IDLE && rd_count_reg != '1)
                rd_count_reg <= rd_count_reg + CNT_W'(1);
            if (state_reg == WAIT && state_next == WACK && wr_count_reg != '1)
                wr_count_reg <= wr_count_reg + CNT_W'(1);
        end
    end

    // Array port: writes land on the beat handshake, reads prefetch the beat
    // presented next so rsp_data is stable while rsp_ready is low.
    always_ff @(posedge clk) begin
        if (!rst && wd_hs) mem[{addr_reg, beat_cnt_reg}] <= wd_data;
    end

    always_ff @(posedge clk) begin
        if (rst)                       rsp_data_reg <= '0;
        else if (state_next == RBURST) rsp_data_reg <= mem[rd_addr];
    end

    assign req_ready = req_ready_reg;
    assign wd_ready  = wd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_last  = rsp_last_reg;
    assign rsp_data  = rsp_data_reg;
    assign wr_ack    = wr_ack_reg;
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed fills/writebacks against a shadow line
// array and saturating counters, checked every cycle on the falling edge.
module tb_mem_responder;
    localparam int DATA_W      = 32;
    localparam int LINE_ADDR_W = 6;
    localparam int BEATS       = 4;
    localparam int LATENCY     = 3;
    localparam int CNT_W       = 2;
    localparam int NLINES      = 2 ** LINE_ADDR_W;
    localparam int CNT_MAX     = 2 ** CNT_W - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid, req_ready, req_we;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic wd_valid, wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic rsp_valid, rsp_ready, rsp_last, wr_ack;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0] rd_count, wr_count;

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_W(DATA_W), .LINE_ADDR_W(LINE_ADDR_W), .BEATS(BEATS),
        .LATENCY(LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .wr_ack(wr_ack), .rd_count(rd_count), .wr_count(wr_count)
    );

    int checks = 0;
    int fails  = 0;

    // Shadow model: line array, saturating counters, burst progress.
    logic [DATA_W-1:0] model_mem [NLINES*BEATS];
    int  exp_rd = 0, exp_wr = 0;
    int  rd_line = 0, rd_beat = 0;
    bit  rd_active = 1'b0;
    int  wr_line = 0, wr_beat = 0;
    int  rst_cycles = 0;
    logic [DATA_W-1:0] got [BEATS];
    int  sat_exp [5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rst_cycles > 0)
                chk("reset_outputs", {req_ready, wd_ready, rsp_valid, rsp_last, wr_ack,
                                      rsp_data, rd_count, wr_count}, '0);
            rst_cycles++;
            exp_rd    = 0;
            exp_wr    = 0;
            rd_active = 1'b0;
            rd_beat   = 0;
        end else begin
            rst_cycles = 0;
            if (wr_ack) exp_wr = (exp_wr == CNT_MAX) ? exp_wr : exp_wr + 1;
            chk("rd_count", rd_count, exp_rd);
            chk("wr_count", wr_count, exp_wr);
            if (rsp_valid) begin
                chk("rsp_unexpected", rd_active, 1);
                chk("rsp_data", rsp_data, model_mem[rd_line*BEATS + rd_beat]);
                chk("rsp_last", rsp_last, rd_beat == BEATS - 1);
                if (rsp_ready) begin
                    if (rd_beat == BEATS - 1) begin
                        rd_active = 1'b0;
                        rd_beat   = 0;
                        exp_rd    = (exp_rd == CNT_MAX) ? exp_rd : exp_rd + 1;
                    end else begin
                        rd_beat++;
                    end
                end
            end
            if (wd_valid && wd_ready) begin
                model_mem[wr_line*BEATS + wr_beat] = wd_data;
                wr_beat = (wr_beat + 1) % BEATS;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
    endtask

    // abort_after: assert rst instead of handshaking that beat (-1 = never)
    task automatic do_read(input int line, input int stall_beat, input int stall_n,
                           input int abort_after);
        int n;
        rsp_ready = 1'b1;
        wait_ready();
        rd_line   = line;
        rd_beat   = 0;
        rd_active = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = line[LINE_ADDR_W-1:0];
        tick();
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("read_latency", n, LATENCY);
        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_after) begin
                rst = 1'b1;
                tick();
                chk("abort_rsp_valid", rsp_valid, 0);
                rst = 1'b0;
                tick();
                return;
            end
            if (b == stall_beat) begin
                rsp_ready = 1'b0;
                repeat (stall_n) tick();
                rsp_ready = 1'b1;
            end
            chk("burst_valid", rsp_valid, 1);
            got[b] = rsp_data;
            tick();
        end
        chk("rsp_valid_after_last", rsp_valid, 0);
        chk("req_ready_after_last", req_ready, 1);
    endtask

    task automatic do_write(input int line, input logic [DATA_W-1:0] base, input bit gap);
        int n;
        wait_ready();
        wr_line   = line;
        wr_beat   = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = line[LINE_ADDR_W-1:0];
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (gap && b == 1) begin
                wd_valid = 1'b0;
                tick();
            end
            wd_valid = 1'b1;
            wd_data  = base + DATA_W'(b);
            n = 0;
            while (!wd_ready && n < 20) begin
                tick();
                n++;
            end
            chk("wd_ready", wd_ready, 1);
            tick();
        end
        wd_valid = 1'b0;
        n = 0;
        while (!wr_ack && n < 20) begin
            tick();
            n++;
        end
        chk("wr_ack_latency", n, LATENCY);
        tick();
        chk("wr_ack_pulse", wr_ack, 0);
        chk("req_ready_after_ack", req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        wd_valid  = 1'b0; wd_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NLINES*BEATS; i++) model_mem[i] = '0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("req_ready_in_reset", req_ready, 0);
        tick();
        chk("req_ready_after_reset", req_ready, 1);
        chk("rd_count_reset", rd_count, 0);
        chk("wr_count_reset", wr_count, 0);

        do_read(5, -1, 0, -1);
        for (int b = 0; b < BEATS; b++) chk("fresh_line", got[b], 0);
        chk("rd_count_one", rd_count, 1);

        do_write(5, 32'hA000_0000, 1'b1);
        chk("wr_count_one", wr_count, 1);
        do_read(5, -1, 0, -1);
        chk("raw_beat0", got[0], 32'hA000_0000);
        chk("raw_beat1", got[1], 32'hA000_0001);
        chk("raw_beat2", got[2], 32'hA000_0002);
        chk("raw_beat3", got[3], 32'hA000_0003);

        do_write(63, 32'h5EED_0000, 1'b0);
        do_write(0, 32'h0000_C0D0, 1'b0);
        chk("wr_count_sat", wr_count, 3);
        do_read(63, -1, 0, -1);
        chk("top_line_beat0", got[0], 32'h5EED_0000);
        chk("top_line_beat3", got[3], 32'h5EED_0003);

        do_read(5, 2, 5, -1);
        chk("stall_beat2", got[2], 32'hA000_0002);
        chk("stall_beat3", got[3], 32'hA000_0003);

        do_read(5, -1, 0, 2);
        chk("rd_count_after_abort", rd_count, 0);
        do_read(5, -1, 0, -1);
        chk("refill_beat0", got[0], 32'hA000_0000);
        chk("refill_beat3", got[3], 32'hA000_0003);
        chk("rd_count_refill", rd_count, 1);

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            do_read(5, -1, 0, -1);
            chk("rd_count_sat", rd_count, sat_exp[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
